// File: rtl/mem_responder.sv
// Multi-channel valid/ready memory endpoint: one request in flight per channel,
// fixed read/write latency, one-cycle ready pulse, shared word store with preload.
module mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CHANNELS  = 1,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] mem_read_valid,
  input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_read_ready,
  output logic [DATA_BITS-1:0]    mem_read_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] mem_write_valid,
  input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]    mem_write_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_write_ready,
  input  logic                    init_valid,
  input  logic [ADDR_BITS-1:0]    init_address,
  input  logic [DATA_BITS-1:0]    init_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_BUSY,
    ST_WRITE_BUSY,
    ST_READ_RESPOND,
    ST_WRITE_RESPOND,
    ST_RELEASE
  } state_t;

  localparam int         DEPTH   = 2 ** ADDR_BITS;
  localparam logic [3:0] RD_CNT0 = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_CNT0 = 4'(WRITE_LATENCY - 1);

  state_t                  r_state   [NUM_CHANNELS];
  logic [3:0]              r_cnt     [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    r_addr    [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    r_wdata   [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    r_rd_data [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_rd_ready;
  logic [NUM_CHANNELS-1:0] r_wr_ready;
  logic [DATA_BITS-1:0]    r_mem     [DEPTH];

  logic [NUM_CHANNELS-1:0] w_rd_capture;
  logic [NUM_CHANNELS-1:0] w_wr_commit;
  logic [ADDR_BITS-1:0]    w_rd_addr [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    w_wr_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    w_wr_data [NUM_CHANNELS];

  // Edges that enter a RESPOND state; latency 1 enters straight from IDLE with live inputs.
  always_comb begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      w_rd_capture[ch] = 1'b0;
      w_wr_commit[ch]  = 1'b0;
      w_rd_addr[ch]    = r_addr[ch];
      w_wr_addr[ch]    = r_addr[ch];
      w_wr_data[ch]    = r_wdata[ch];
      case (r_state[ch])
        ST_IDLE: begin
          if (mem_read_valid[ch]) begin
            if (READ_LATENCY == 1) begin
              w_rd_capture[ch] = 1'b1;
              w_rd_addr[ch]    = mem_read_address[ch];
            end
          end else if (mem_write_valid[ch] && (WRITE_LATENCY == 1)) begin
            w_wr_commit[ch] = 1'b1;
            w_wr_addr[ch]   = mem_write_address[ch];
            w_wr_data[ch]   = mem_write_data[ch];
          end
        end
        ST_READ_BUSY:  w_rd_capture[ch] = (r_cnt[ch] <= 4'd1);
        ST_WRITE_BUSY: w_wr_commit[ch]  = (r_cnt[ch] <= 4'd1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        r_state[ch]    <= ST_IDLE;
        r_cnt[ch]      <= 4'd0;
        r_rd_data[ch]  <= '0;
        r_rd_ready[ch] <= 1'b0;
        r_wr_ready[ch] <= 1'b0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        r_rd_ready[ch] <= w_rd_capture[ch];
        r_wr_ready[ch] <= w_wr_commit[ch];
        if (w_rd_capture[ch]) r_rd_data[ch] <= r_mem[w_rd_addr[ch]];
        case (r_state[ch])
          ST_IDLE: begin
            if (mem_read_valid[ch]) begin
              r_addr[ch] <= mem_read_address[ch];
              r_cnt[ch]  <= RD_CNT0;
              r_state[ch] <= (READ_LATENCY == 1) ? ST_READ_RESPOND : ST_READ_BUSY;
            end else if (mem_write_valid[ch]) begin
              r_addr[ch]  <= mem_write_address[ch];
              r_wdata[ch] <= mem_write_data[ch];
              r_cnt[ch]   <= WR_CNT0;
              r_state[ch] <= (WRITE_LATENCY == 1) ? ST_WRITE_RESPOND : ST_WRITE_BUSY;
            end
          end
          ST_READ_BUSY: begin
            r_cnt[ch] <= r_cnt[ch] - 4'd1;
            if (r_cnt[ch] <= 4'd1) r_state[ch] <= ST_READ_RESPOND;
          end
          ST_WRITE_BUSY: begin
            r_cnt[ch] <= r_cnt[ch] - 4'd1;
            if (r_cnt[ch] <= 4'd1) r_state[ch] <= ST_WRITE_RESPOND;
          end
          ST_READ_RESPOND, ST_WRITE_RESPOND: r_state[ch] <= ST_RELEASE;
          // A valid still held from the finished request must drop before a new one is taken.
          ST_RELEASE: if (!mem_read_valid[ch] && !mem_write_valid[ch]) r_state[ch] <= ST_IDLE;
          default: r_state[ch] <= ST_IDLE;
        endcase
      end
    end
  end

  // Preload first so that channel writes override it; higher channels override lower.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (init_valid) r_mem[init_address] <= init_data;
      if (WRITE_ENABLE != 0) begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
          if (w_wr_commit[ch]) r_mem[w_wr_addr[ch]] <= w_wr_data[ch];
        end
      end
    end
  end

  assign mem_read_ready  = r_rd_ready;
  assign mem_write_ready = r_wr_ready;
  assign mem_read_data   = r_rd_data;

endmodule
